// File: rtl/snake_move_scheduler.sv
// snake_move_scheduler
//
// Paces snake movement. Counts VGA frames (falling edges of VS) and raises
// MOVE_REQ once per move period. Each move commits the player's latest legal
// heading on DIRECTION. The snake-position datapath consumes moves over a
// MOVE_REQ/MOVE_ACK handshake.
//
// Optional feature macro: SNAKE_SCHED_SPEEDUP_EN
//   defined   : move period shrinks with SCORE_COUNT, floored at FRAMES_MIN
//   undefined : move period is always FRAMES_BASE, SCORE_COUNT is ignored
//
// Ports:
//   CLK          in   system/pixel clock
//   RESET        in   asynchronous active-low reset
//   M_STATE[1:0] in   game state, 01 = play, anything else = not playing
//   VS           in   vertical sync, active-low, synchronous to CLK
//   LEFT/RIGHT/UP/DOWN in  debounced button levels
//   SCORE_COUNT[3:0]   in  current score
//   MOVE_ACK     in   datapath consumed the pending move
//   MOVE_REQ     out  move pending (registered)
//   DIRECTION[1:0] out committed heading: 00 up, 01 right, 10 down, 11 left
module snake_move_scheduler #(
  parameter int unsigned FRAMES_BASE = 30,
  parameter int unsigned FRAMES_STEP = 2,
  parameter int unsigned FRAMES_MIN  = 6
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] M_STATE,
  input  logic       VS,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       UP,
  input  logic       DOWN,
  input  logic [3:0] SCORE_COUNT,
  input  logic       MOVE_ACK,
  output logic       MOVE_REQ,
  output logic [1:0] DIRECTION
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_REQ   = 2'b10
  } state_t;

  localparam logic [1:0] M_PLAY    = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  state_t     r_state;
  logic       r_move_req;
  logic [1:0] r_direction;
  logic [1:0] r_pending;
  logic [5:0] r_count;
  logic       r_vs_q;
  logic [3:0] r_btn_q;

  logic       w_play;
  logic       w_tick;
  logic [3:0] w_btn;
  logic [3:0] w_cand;
  logic [1:0] w_reverse;
  logic       w_sel_valid;
  logic [1:0] w_sel_dir;
  logic [5:0] w_period;

  assign w_play = (M_STATE == M_PLAY);

  // One-cycle pulse on the clock edge that first sees VS low.
  assign w_tick = r_vs_q & ~VS;

  // Bit index equals the direction code, so index order is also priority order.
  assign w_btn = {LEFT, DOWN, RIGHT, UP};

  // Opposite heading differs only in the MSB of the code.
  assign w_reverse = r_direction ^ 2'b10;

  // Candidate = rising edge of the button that does not reverse the heading.
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    assign w_cand[gi] = w_btn[gi] & ~r_btn_q[gi] & (w_reverse != 2'(gi));
  end

  // Highest-priority legal edge: UP > RIGHT > DOWN > LEFT.
  always_comb begin
    w_sel_valid = 1'b1;
    w_sel_dir   = 2'd0;
    if (w_cand[0]) begin
      w_sel_dir = 2'd0;
    end else if (w_cand[1]) begin
      w_sel_dir = 2'd1;
    end else if (w_cand[2]) begin
      w_sel_dir = 2'd2;
    end else if (w_cand[3]) begin
      w_sel_dir = 2'd3;
    end else begin
      w_sel_valid = 1'b0;
    end
  end

`ifdef SNAKE_SCHED_SPEEDUP_EN
  localparam logic [9:0] C_BASE = 10'(FRAMES_BASE);
  localparam logic [9:0] C_STEP = 10'(FRAMES_STEP);
  localparam logic [9:0] C_MIN  = 10'(FRAMES_MIN);

  logic [9:0] w_dec;

  // 10-bit arithmetic keeps the subtraction from wrapping; the comparison
  // selects the floor before the difference could drop below FRAMES_MIN.
  assign w_dec    = C_STEP * {6'd0, SCORE_COUNT};
  assign w_period = ((w_dec + C_MIN) >= C_BASE) ? 6'(FRAMES_MIN) : 6'(C_BASE - w_dec);
`else
  logic w_unused_score;

  assign w_unused_score = ^SCORE_COUNT;
  assign w_period       = 6'(FRAMES_BASE);
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_move_req  <= 1'b0;
      r_direction <= DIR_RIGHT;
      r_pending   <= DIR_RIGHT;
      r_count     <= 6'(FRAMES_BASE);
      r_vs_q      <= 1'b1;
      r_btn_q     <= 4'b0000;
    end else begin
      r_vs_q  <= VS;
      r_btn_q <= w_btn;

      // Edges captured while playing; the IDLE entry below overrides this.
      if (w_play && w_sel_valid) begin
        r_pending <= w_sel_dir;
      end

      case (r_state)
        S_IDLE: begin
          r_move_req <= 1'b0;
          if (w_play) begin
            r_count     <= w_period;
            r_direction <= DIR_RIGHT;
            r_pending   <= DIR_RIGHT;
            r_state     <= S_COUNT;
          end
        end

        S_COUNT: begin
          if (!w_play) begin
            r_move_req <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_tick) begin
            if (r_count == 6'd1) begin
              // Period expires: reload now so the next period starts here.
              r_count     <= w_period;
              r_move_req  <= 1'b1;
              r_direction <= r_pending;
              r_state     <= S_REQ;
            end else begin
              r_count <= r_count - 6'd1;
            end
          end
        end

        S_REQ: begin
          // Counter frozen while waiting; late moves are not queued.
          if (!w_play) begin
            r_move_req <= 1'b0;
            r_state    <= S_IDLE;
          end else if (MOVE_ACK) begin
            r_move_req <= 1'b0;
            r_state    <= S_COUNT;
          end
        end

        default: begin
          r_move_req <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign MOVE_REQ  = r_move_req;
  assign DIRECTION = r_direction;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Testbench for snake_move_scheduler. Drives randomized VS frame lengths and
// button presses; expected move spacing and committed headings come from a
// small game-rule model (period formula, priority/reversal rules).
module tb_snake_move_scheduler;

  localparam int BASE = 30;
  localparam int STEP = 2;
  localparam int MIN  = 6;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic [1:0] m_state = 2'b00;
  logic       vs      = 1'b1;
  logic       left    = 1'b0;
  logic       right   = 1'b0;
  logic       up      = 1'b0;
  logic       down    = 1'b0;
  logic [3:0] score   = 4'd0;
  logic       ack     = 1'b0;
  logic       move_req;
  logic [1:0] direction;

  int   check_cnt = 0;
  int   pass_cnt  = 0;
  logic prev_req  = 1'b0;

  // Model state: committed heading and latest accepted intent (direction codes).
  int m_heading = 1;
  int m_intent  = 1;

  always #5 clk = ~clk;

  snake_move_scheduler dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .M_STATE    (m_state),
    .VS         (vs),
    .LEFT       (left),
    .RIGHT      (right),
    .UP         (up),
    .DOWN       (down),
    .SCORE_COUNT(score),
    .MOVE_ACK   (ack),
    .MOVE_REQ   (move_req),
    .DIRECTION  (direction)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  // Frames per move for a given score.
  function automatic int period_for(input int s);
    int p;
    p = BASE - STEP * s;
    if (p < MIN) p = MIN;
`ifndef SNAKE_SCHED_SPEEDUP_EN
    p = BASE;
`endif
    return p;
  endfunction

  // Press set p (bit0 up, bit1 right, bit2 down, bit3 left): first pressed
  // direction in priority order that is not opposite the heading wins.
  function automatic void model_press(input logic [3:0] p);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!done && p[k] && (k != (m_heading + 2) % 4)) begin
        m_intent = k;
        done     = 1'b1;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_play();
    m_state = 2'b00;
    vs      = 1'b1;
    step();
    step();
    m_state = 2'b01;
    step();
    m_heading = 1;
    m_intent  = 1;
    prev_req  = move_req;
  endtask

  // Runs VS frames until MOVE_REQ rises or limit frames elapse.
  task automatic wait_move(input bit rand_press, input int press_frame, input logic [3:0] press_val,
                           input int limit, output bit got, output int frames,
                           output bit aligned, output int pulse);
    int         lo;
    int         hi;
    logic [3:0] p;
    got = 1'b0; frames = 0; aligned = 1'b0; pulse = 0;
    while (!got && frames < limit) begin
      frames++;
      lo = $urandom_range(1, 3);
      hi = $urandom_range(1, 3);
      vs = 1'b0;
      for (int i = 0; i < lo; i++) begin
        step();
        if (move_req && !prev_req && !got) begin
          got       = 1'b1;
          aligned   = (i == 0);
          m_heading = m_intent;
        end
        if (got && move_req) pulse++;
        prev_req = move_req;
      end
      vs = 1'b1;
      for (int i = 0; i < hi; i++) begin
        p = 4'b0000;
        if (i == 0) begin
          if (frames == press_frame) p = press_val;
          else if (rand_press && $urandom_range(0, 3) == 0) p = 4'($urandom_range(1, 15));
        end
        {left, down, right, up} = p;
        if (p != 4'b0000) model_press(p);
        step();
        {left, down, right, up} = 4'b0000;
        if (got && move_req) pulse++;
        prev_req = move_req;
      end
    end
    $display("move: got=%0d frames=%0d dir=%0d req_cycles=%0d", got, frames, direction, pulse);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if (move_req !== 1'b0) $display("FAIL reset_req_async: got %0b required 0", move_req);
    else pass_cnt++;
    check_cnt++;
    if (direction !== 2'b01) $display("FAIL reset_dir_async: got %0d required 1", direction);
    else pass_cnt++;
    step();
    check_cnt++;
    if (move_req !== 1'b0) $display("FAIL reset_req_held: got %0b required 0", move_req);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    step();
    check_cnt++;
    if (direction !== 2'b01 || move_req !== 1'b0)
      $display("FAIL reset_release: got req=%0b dir=%0d required req=0 dir=1", move_req, direction);
    else pass_cnt++;
  endtask

  task automatic test_period();
    bit got; int fr; bit al; int pu;
    ack = 1'b1; score = 4'd0;
    enter_play();
    for (int m = 0; m < 3; m++) begin
      wait_move(1'b0, 0, 4'b0000, BASE + 4, got, fr, al, pu);
      check_cnt++;
      if (fr !== period_for(0) || !got) $display("FAIL period_frames: got %0d (req=%0b) required %0d", fr, got, period_for(0));
      else pass_cnt++;
      check_cnt++;
      if (al !== 1'b1) $display("FAIL period_aligned: got %0b required 1", al);
      else pass_cnt++;
      check_cnt++;
      if (pu !== 1) $display("FAIL period_pulse_len: got %0d required 1", pu);
      else pass_cnt++;
      check_cnt++;
      if (direction !== 2'b01) $display("FAIL period_dir: got %0d required 1", direction);
      else pass_cnt++;
    end
  endtask

  task automatic test_speedup();
    bit got; int fr; bit al; int pu;
    int exp_p[4];
    ack = 1'b1; score = 4'd10;
    exp_p[0] = period_for(10); exp_p[1] = period_for(10);
    exp_p[2] = period_for(15); exp_p[3] = period_for(15);
    enter_play();
    for (int m = 0; m < 4; m++) begin
      if (m == 1) score = 4'd15;   // mid-period change: takes effect on next reload
      wait_move(1'b0, 0, 4'b0000, BASE + 4, got, fr, al, pu);
      check_cnt++;
      if (fr !== exp_p[m] || !got) $display("FAIL speedup_frames_%0d: got %0d (req=%0b) required %0d", m, fr, got, exp_p[m]);
      else pass_cnt++;
      check_cnt++;
      if (al !== 1'b1 || pu !== 1) $display("FAIL speedup_pulse_%0d: got aligned=%0b len=%0d required 1/1", m, al, pu);
      else pass_cnt++;
    end
  endtask

  task automatic test_direction();
    bit got; int fr; bit al; int pu;
    logic [3:0] directed[4];
    directed[0] = 4'b1000;   // LEFT while heading right: rejected
    directed[1] = 4'b0001;   // UP
    directed[2] = 4'b0010;   // RIGHT
    directed[3] = 4'b1001;   // UP and LEFT together
    ack = 1'b1; score = 4'd0;
    enter_play();
    for (int m = 0; m < 10; m++) begin
      if (m < 4) wait_move(1'b0, 2, directed[m], BASE + 4, got, fr, al, pu);
      else       wait_move(1'b1, 0, 4'b0000, BASE + 4, got, fr, al, pu);
      check_cnt++;
      if (direction !== 2'(m_heading) || !got)
        $display("FAIL direction_%0d: got %0d (req=%0b) required %0d", m, direction, got, m_heading);
      else pass_cnt++;
      check_cnt++;
      if (fr !== period_for(0)) $display("FAIL direction_frames_%0d: got %0d required %0d", m, fr, period_for(0));
      else pass_cnt++;
    end
  endtask

  task automatic test_ack_late();
    bit got; int fr; bit al; int pu;
    ack = 1'b0; score = 4'd0;
    enter_play();
    wait_move(1'b0, 0, 4'b0000, BASE + 4, got, fr, al, pu);
    check_cnt++;
    if (fr !== period_for(0) || !got) $display("FAIL ack_first_req: got %0d (req=%0b) required %0d", fr, got, period_for(0));
    else pass_cnt++;
    wait_move(1'b0, 0, 4'b0000, 3, got, fr, al, pu);
    check_cnt++;
    if (got !== 1'b0) $display("FAIL ack_no_extra_req: got %0b required 0", got);
    else pass_cnt++;
    check_cnt++;
    if (move_req !== 1'b1) $display("FAIL ack_req_held: got %0b required 1", move_req);
    else pass_cnt++;
    ack = 1'b1;
    step();
    prev_req = move_req;
    check_cnt++;
    if (move_req !== 1'b0) $display("FAIL ack_clears_req: got %0b required 0", move_req);
    else pass_cnt++;
    wait_move(1'b0, 0, 4'b0000, BASE + 4, got, fr, al, pu);
    check_cnt++;
    if (fr !== period_for(0) || !got) $display("FAIL ack_next_req: got %0d (req=%0b) required %0d", fr, got, period_for(0));
    else pass_cnt++;
    check_cnt++;
    if (pu !== 1) $display("FAIL ack_next_pulse: got %0d required 1", pu);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    bit got; int fr; bit al; int pu;
    ack = 1'b0; score = 4'd0;
    enter_play();
    wait_move(1'b0, 2, 4'b0001, BASE + 4, got, fr, al, pu);
    check_cnt++;
    if (direction !== 2'(m_heading) || !got) $display("FAIL abort_pre_dir: got %0d (req=%0b) required %0d", direction, got, m_heading);
    else pass_cnt++;
    m_state = 2'b10;
    step();
    prev_req = move_req;
    check_cnt++;
    if (move_req !== 1'b0) $display("FAIL abort_req_cleared: got %0b required 0", move_req);
    else pass_cnt++;
    wait_move(1'b0, 0, 4'b0000, 3, got, fr, al, pu);
    check_cnt++;
    if (got !== 1'b0 || move_req !== 1'b0) $display("FAIL abort_idle_quiet: got req=%0b rise=%0b required 0/0", move_req, got);
    else pass_cnt++;
    m_state = 2'b01;
    step();
    m_heading = 1; m_intent = 1; prev_req = move_req;
    check_cnt++;
    if (direction !== 2'b01) $display("FAIL abort_return_dir: got %0d required 1", direction);
    else pass_cnt++;
    ack = 1'b1;
    wait_move(1'b0, 0, 4'b0000, BASE + 4, got, fr, al, pu);
    check_cnt++;
    if (fr !== period_for(0) || !got) $display("FAIL abort_full_period: got %0d (req=%0b) required %0d", fr, got, period_for(0));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    bit got; int fr; bit al; int pu;
    ack = 1'b0; score = 4'd0;
    enter_play();
    wait_move(1'b0, 2, 4'b0001, BASE + 4, got, fr, al, pu);
    check_cnt++;
    if (direction !== 2'b00 || move_req !== 1'b1) $display("FAIL rstmid_pre: got req=%0b dir=%0d required req=1 dir=0", move_req, direction);
    else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    check_cnt++;
    if (move_req !== 1'b0) $display("FAIL rstmid_req_async: got %0b required 0", move_req);
    else pass_cnt++;
    check_cnt++;
    if (direction !== 2'b01) $display("FAIL rstmid_dir_async: got %0d required 1", direction);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    step();
    m_heading = 1; m_intent = 1; prev_req = move_req;
    ack = 1'b1;
    wait_move(1'b0, 0, 4'b0000, BASE + 4, got, fr, al, pu);
    check_cnt++;
    if (fr !== period_for(0) || !got) $display("FAIL rstmid_full_period: got %0d (req=%0b) required %0d", fr, got, period_for(0));
    else pass_cnt++;
    check_cnt++;
    if (direction !== 2'b01) $display("FAIL rstmid_dir_after: got %0d required 1", direction);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_period();
    test_speedup();
    test_direction();
    test_ack_late();
    test_abort();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
